// File: rtl/pulse_decoder.sv
// Sequential 4-to-16 decoder: turns a handshaked 4-bit code into a one-hot strobe held
// PULSE_LEN cycles, then enforces GAP_LEN idle cycles before the next code is accepted.
module pulse_decoder #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  code_in,
  input  logic        code_valid,
  output logic        code_ready,
  output logic [15:0] dec_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] PULSE_CNT = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_CNT   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

  logic [1:0] state;
  logic [7:0] cnt;

  // Ready is held low during reset so upstream never sees an accept it cannot get.
  assign code_ready = enable && !reset && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      dec_out <= 16'h0000;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        // Abort: drop the strobe immediately and suppress the completion strobe.
        state   <= ST_IDLE;
        cnt     <= 8'd0;
        dec_out <= 16'h0000;
      end else begin
        case (state)
          ST_IDLE: begin
            if (code_valid) begin
              dec_out <= 16'b1 << code_in;
              cnt     <= PULSE_CNT;
              state   <= ST_PULSE;
            end
          end
          ST_PULSE: begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else begin
              dec_out <= 16'h0000;
              done    <= 1'b1;
              if (GAP_LEN > 0) begin
                state <= ST_GAP;
                cnt   <= GAP_CNT;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_GAP: begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            dec_out <= 16'h0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// Directed bench: u0 runs with P=4/G=2, u1 with P=1/G=0 for the exhaustive back-to-back sweep.
module tb_pulse_decoder;

  logic        clk;
  logic        reset;
  logic        enable, code_valid, code_ready, busy, done;
  logic [3:0]  code_in;
  logic [15:0] dec_out;
  logic        enable1, code_valid1, code_ready1, busy1, done1;
  logic [3:0]  code_in1;
  logic [15:0] dec_out1;

  int errors = 0;
  int checks = 0;

  pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(2)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .code_in(code_in),
    .code_valid(code_valid), .code_ready(code_ready), .dec_out(dec_out),
    .busy(busy), .done(done)
  );

  pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u1 (
    .clk(clk), .reset(reset), .enable(enable1), .code_in(code_in1),
    .code_valid(code_valid1), .code_ready(code_ready1), .dec_out(dec_out1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; inputs are driven here, outputs read 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; code_valid = 1'b1; code_in = 4'd3;
    enable1 = 1'b0; code_valid1 = 1'b0; code_in1 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++;
      if (dec_out !== 16'h0000 || done !== 1'b0 || busy !== 1'b0 || code_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals cyc%0d: dec=%h done=%b busy=%b rdy=%b, want 0000 0 0 0",
                 i, dec_out, done, busy, code_ready);
      end
    end
    tick();
    reset = 1'b0; code_valid = 1'b0;
    #1;
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", code_ready);
    end
  endtask

  task automatic test_single_pulse();
    code_in = 4'd9; code_valid = 1'b1;
    #1;
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_accept_ready: got %b want 1", code_ready);
    end
    tick(); code_valid = 1'b0; #1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (dec_out !== 16'h0200 || busy !== 1'b1 || done !== 1'b0 || code_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse k+%0d: dec=%h busy=%b done=%b rdy=%b, want 0200 1 0 0",
                 i, dec_out, busy, done, code_ready);
      end
      tick(); #1;
    end
    checks++;
    if (dec_out !== 16'h0000 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done k+5: dec=%h done=%b busy=%b, want 0000 1 1", dec_out, done, busy);
    end
    tick(); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || code_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_gap k+6: done=%b busy=%b rdy=%b, want 0 1 0", done, busy, code_ready);
    end
    tick(); #1;
    checks++;
    if (code_ready !== 1'b1 || busy !== 1'b0 || dec_out !== 16'h0000) begin
      errors++;
      $display("FAIL single_idle k+7: rdy=%b busy=%b dec=%h, want 1 0 0000", code_ready, busy, dec_out);
    end
  endtask

  task automatic test_exhaustive_codes();
    logic [15:0] exp_v;
    int ndone = 0;
    enable1 = 1'b1; code_valid1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      code_in1 = 4'(c);
      #1;
      checks++;
      if (code_ready1 !== 1'b1 || dec_out1 !== 16'h0000) begin
        errors++;
        $display("FAIL exh_idle code%0d: rdy=%b dec=%h, want 1 0000", c, code_ready1, dec_out1);
      end
      tick(); #1;
      exp_v = 16'h0001 << c;
      checks++;
      if (dec_out1 !== exp_v || done1 !== 1'b0) begin
        errors++;
        $display("FAIL exh_pulse code%0d: dec=%h done=%b, want %h 0", c, dec_out1, done1, exp_v);
      end
      tick();
      if (done1 === 1'b1) ndone++;
    end
    code_valid1 = 1'b0;
    checks++;
    if (ndone != 16) begin
      errors++;
      $display("FAIL exh_done_count: got %0d want 16", ndone);
    end
    enable1 = 1'b0;
  endtask

  task automatic test_abort();
    int budget;
    code_in = 4'd5; code_valid = 1'b1;
    tick(); code_valid = 1'b0; #1;
    checks++;
    if (dec_out !== 16'h0020) begin
      errors++;
      $display("FAIL abort_pulse k+1: dec=%h want 0020", dec_out);
    end
    tick(); enable = 1'b0; #1;
    checks++;
    if (dec_out !== 16'h0020 || code_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_k2: dec=%h rdy=%b, want 0020 0", dec_out, code_ready);
    end
    tick(); #1;
    checks++;
    if (dec_out !== 16'h0000 || done !== 1'b0 || busy !== 1'b0 || code_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_k3: dec=%h done=%b busy=%b rdy=%b, want 0000 0 0 0",
               dec_out, done, busy, code_ready);
    end
    code_valid = 1'b1; code_in = 4'd7;
    tick(); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dec_out !== 16'h0000) begin
      errors++;
      $display("FAIL abort_disabled_idle: done=%b busy=%b dec=%h, want 0 0 0000", done, busy, dec_out);
    end
    enable = 1'b1; code_in = 4'd12;
    #1;
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reenable_ready: got %b want 1", code_ready);
    end
    tick(); code_valid = 1'b0; #1;
    checks++;
    if (dec_out !== 16'h1000) begin
      errors++;
      $display("FAIL abort_new_code: dec=%h want 1000", dec_out);
    end
    budget = 0;
    while (code_ready !== 1'b1 && budget < 20) begin
      tick(); #1;
      budget++;
    end
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_return_idle: timed out, rdy=%b want 1", code_ready);
    end
  endtask

  task automatic test_ignore_busy();
    logic [3:0] noise [6] = '{4'd7, 4'd15, 4'd0, 4'd1, 4'd14, 4'd6};
    int ndone = 0;
    code_in = 4'd3; code_valid = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      code_in = noise[i];
      #1;
      if (done === 1'b1) ndone++;
      if (i < 4) begin
        checks++;
        if (dec_out !== 16'h0008) begin
          errors++;
          $display("FAIL ignore_hold k+%0d: dec=%h want 0008", i + 1, dec_out);
        end
      end
      tick();
    end
    code_in = 4'd10;
    #1;
    checks++;
    if (ndone != 1 || code_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done_ready: dones=%0d rdy=%b, want 1 1", ndone, code_ready);
    end
    tick(); code_valid = 1'b0; #1;
    checks++;
    if (dec_out !== 16'h0400) begin
      errors++;
      $display("FAIL ignore_next_code: dec=%h want 0400", dec_out);
    end
  endtask

  // Entered one cycle into the code-10 pulse started by test_ignore_busy.
  task automatic test_reset_mid_gap();
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b1 || dec_out !== 16'h0000) begin
      errors++;
      $display("FAIL gap_entry: busy=%b done=%b dec=%h, want 1 1 0000", busy, done, dec_out);
    end
    reset = 1'b1;
    tick(); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dec_out !== 16'h0000 || code_ready !== 1'b0) begin
      errors++;
      $display("FAIL gap_reset: busy=%b done=%b dec=%h rdy=%b, want 0 0 0000 0",
               busy, done, dec_out, code_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_reset_release: rdy=%b want 1", code_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_exhaustive_codes();
    test_abort();
    test_ignore_busy();
    test_reset_mid_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
